pipeline_control: RTL and testbench

Central stall/flush sequencer for the 5-stage pipeline. It merges the load-use stall request from hazard detection, taken-branch and jump redirects, and data-memory wait states into one prioritised set of pipeline-register write enables and flush controls. It also keeps stall/flush performance counters and a sticky memory-timeout error flag. It sits beside the hazard detection unit in the top-level datapath and drives the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB registers.

---
 rtl/pipeline_control_if.sv | 33 +++
 rtl/pipeline_control.sv | 119 +++++++++++
 tb/tb_pipeline_control.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/pipeline_control_if.sv
// pipeline_control_if: hazard/memory requests into the pipeline sequencer and
// the resulting pipeline-register enables, flush controls, state and counters.
//   master: hazard/memory sources (drives requests, observes controls)
//   slave : pipeline_control (consumes requests, drives controls)
interface pipeline_control_if;
    logic        LoadUseHazard;
    logic        BranchTaken;
    logic        Jump;
    logic        MemReq;
    logic        MemReady;
    logic        PCWrite;
    logic        IF_ID_Write;
    logic        IF_ID_Flush;
    logic        ID_EX_Write;
    logic        ID_EX_Flush;
    logic        EX_MEM_Write;
    logic        MEM_WB_Bubble;
    logic [1:0]  State;
    logic [31:0] StallCount;
    logic [31:0] FlushCount;
    logic        MemError;

    modport master (
        output LoadUseHazard, BranchTaken, Jump, MemReq, MemReady,
        input  PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Write, ID_EX_Flush,
               EX_MEM_Write, MEM_WB_Bubble, State, StallCount, FlushCount, MemError
    );
    modport slave (
        input  LoadUseHazard, BranchTaken, Jump, MemReq, MemReady,
        output PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Write, ID_EX_Flush,
               EX_MEM_Write, MEM_WB_Bubble, State, StallCount, FlushCount, MemError
    );
endinterface

// File: rtl/pipeline_control.sv
// pipeline_control: prioritised stall/flush sequencer for the 5-stage pipeline.
// Merges load-use stalls, branch/jump redirects and data-memory wait states into
// pipeline-register write enables and flushes. Keeps stall/flush cycle counters
// and a sticky memory-timeout flag.
// Ports:
//   Clk  - rising-edge clock
//   Rst  - synchronous active-low reset
//   bus  - pipeline_control_if.slave: requests in, controls/state/counters out
module pipeline_control #(
    parameter int LOAD_LATENCY = 1,   // 1..15
    parameter int MEM_TIMEOUT  = 255  // 1..255
) (
    input logic              Clk,
    input logic              Rst,
    pipeline_control_if.slave bus
);
    typedef enum logic [1:0] {RUN = 2'd0, LOAD_STALL = 2'd1, MEM_WAIT = 2'd2} state_t;

    state_t      state, state_nxt, ret_state, ret_nxt, rule_state;
    logic [3:0]  dcnt, dcnt_nxt;
    logic [7:0]  wcnt, wcnt_nxt;
    logic        mem_error, err_nxt;
    logic        mem_block;
    logic [31:0] stall_count, flush_count;

    always_comb begin
        bus.PCWrite       = 1'b1;
        bus.IF_ID_Write   = 1'b1;
        bus.IF_ID_Flush   = 1'b0;
        bus.ID_EX_Write   = 1'b1;
        bus.ID_EX_Flush   = 1'b0;
        bus.EX_MEM_Write  = 1'b1;
        bus.MEM_WB_Bubble = 1'b0;
        state_nxt  = state;
        ret_nxt    = ret_state;
        dcnt_nxt   = dcnt;
        wcnt_nxt   = wcnt;
        err_nxt    = mem_error;
        // Once in MEM_WAIT only MemReady matters; on release the saved state's
        // rule runs as if no memory access were pending.
        rule_state = (state == MEM_WAIT) ? ret_state : state;
        mem_block  = (state == MEM_WAIT) ? !bus.MemReady : (bus.MemReq && !bus.MemReady);

        if (!Rst) begin
            bus.PCWrite       = 1'b0;
            bus.IF_ID_Write   = 1'b0;
            bus.IF_ID_Flush   = 1'b1;
            bus.ID_EX_Write   = 1'b0;
            bus.ID_EX_Flush   = 1'b1;
            bus.EX_MEM_Write  = 1'b0;
            bus.MEM_WB_Bubble = 1'b1;
            state_nxt = RUN;
            ret_nxt   = RUN;
            dcnt_nxt  = 4'd0;
            wcnt_nxt  = 8'd0;
            err_nxt   = 1'b0;
        end else if (mem_block) begin
            bus.PCWrite       = 1'b0;
            bus.IF_ID_Write   = 1'b0;
            bus.ID_EX_Write   = 1'b0;
            bus.EX_MEM_Write  = 1'b0;
            bus.MEM_WB_Bubble = 1'b1;
            if (state != MEM_WAIT) begin
                ret_nxt   = state;   // down-counter is held while waiting
                wcnt_nxt  = 8'd1;
                state_nxt = MEM_WAIT;
            end else if (wcnt < 8'(MEM_TIMEOUT)) begin
                wcnt_nxt = wcnt + 8'd1;
            end
            if (wcnt_nxt == 8'(MEM_TIMEOUT))
                err_nxt = 1'b1;
        end else begin
            wcnt_nxt  = 8'd0;
            state_nxt = RUN;
            if (bus.BranchTaken) begin
                // Redirect wins over load-use and jump; a stalled load is squashed.
                bus.IF_ID_Flush = 1'b1;
                bus.ID_EX_Flush = 1'b1;
                dcnt_nxt        = 4'd0;
            end else if (rule_state == LOAD_STALL) begin
                bus.PCWrite     = 1'b0;
                bus.IF_ID_Write = 1'b0;
                bus.ID_EX_Flush = 1'b1;
                dcnt_nxt        = dcnt - 4'd1;
                state_nxt       = (dcnt == 4'd1) ? RUN : LOAD_STALL;
            end else if (bus.LoadUseHazard) begin
                bus.PCWrite     = 1'b0;
                bus.IF_ID_Write = 1'b0;
                bus.ID_EX_Flush = 1'b1;
                if (LOAD_LATENCY > 1) begin
                    dcnt_nxt  = 4'(LOAD_LATENCY - 1);
                    state_nxt = LOAD_STALL;
                end
            end else if (bus.Jump) begin
                bus.IF_ID_Flush = 1'b1;
            end
        end
    end

    always_ff @(posedge Clk) begin
        state     <= state_nxt;
        ret_state <= ret_nxt;
        dcnt      <= dcnt_nxt;
        wcnt      <= wcnt_nxt;
        mem_error <= err_nxt;
        if (!Rst) begin
            stall_count <= 32'd0;
            flush_count <= 32'd0;
        end else begin
            stall_count <= stall_count + {31'd0, !bus.PCWrite};
            flush_count <= flush_count + {31'd0, bus.IF_ID_Flush};
        end
    end

    assign bus.State      = state;
    assign bus.StallCount = stall_count;
    assign bus.FlushCount = flush_count;
    assign bus.MemError   = mem_error;
endmodule

// File: tb/tb_pipeline_control.sv
module tb_pipeline_control;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    pipeline_control_if bus ();
    pipeline_control #(.LOAD_LATENCY(2), .MEM_TIMEOUT(8)) dut (
        .Clk(clk), .Rst(rst), .bus(bus)
    );

    // control bundle order: {PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Write,
    //                        ID_EX_Flush, EX_MEM_Write, MEM_WB_Bubble}
    localparam logic [6:0] DEF = 7'b1101010;
    localparam logic [6:0] STL = 7'b0001110;
    localparam logic [6:0] BRN = 7'b1111110;
    localparam logic [6:0] JMP = 7'b1111010;
    localparam logic [6:0] FRZ = 7'b0000001;
    localparam logic [6:0] RST = 7'b0010101;

    typedef struct {
        logic       lu, br, jp, mreq, mrdy;
        logic [6:0] ctl;
        logic [1:0] st;
        int         sc, fc;
    } vec_t;

    vec_t vecs[22];

    function automatic vec_t mk(logic lu, logic br, logic jp, logic mreq, logic mrdy,
                                logic [6:0] ctl, logic [1:0] st, int sc, int fc);
        vec_t v;
        v.lu = lu; v.br = br; v.jp = jp; v.mreq = mreq; v.mrdy = mrdy;
        v.ctl = ctl; v.st = st; v.sc = sc; v.fc = fc;
        return v;
    endfunction

    function automatic logic [6:0] ctl_now();
        return {bus.PCWrite, bus.IF_ID_Write, bus.IF_ID_Flush, bus.ID_EX_Write,
                bus.ID_EX_Flush, bus.EX_MEM_Write, bus.MEM_WB_Bubble};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic lu, input logic br, input logic jp,
                         input logic mreq, input logic mrdy);
        bus.LoadUseHazard = lu; bus.BranchTaken = br; bus.Jump = jp;
        bus.MemReq = mreq; bus.MemReady = mrdy;
        #2;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0;
        drive(0, 0, 0, 0, 0);
        //                 lu br jp mq mr  ctl  st   sc  fc
        vecs[0]  = mk(0, 0, 0, 0, 0, DEF, 2'd0, 0, 0);
        vecs[1]  = mk(1, 0, 0, 0, 0, STL, 2'd0, 0, 0);   // load-use, latency 2
        vecs[2]  = mk(0, 0, 0, 0, 0, STL, 2'd1, 1, 0);
        vecs[3]  = mk(0, 0, 0, 0, 0, DEF, 2'd0, 2, 0);
        vecs[4]  = mk(1, 0, 0, 0, 0, STL, 2'd0, 2, 0);   // branch in LOAD_STALL
        vecs[5]  = mk(0, 1, 0, 0, 0, BRN, 2'd1, 3, 0);
        vecs[6]  = mk(0, 0, 0, 0, 0, DEF, 2'd0, 3, 1);
        vecs[7]  = mk(0, 0, 1, 0, 0, JMP, 2'd0, 3, 1);   // jump
        vecs[8]  = mk(1, 1, 1, 0, 0, BRN, 2'd0, 3, 2);   // branch beats lu/jump
        vecs[9]  = mk(0, 0, 0, 1, 0, FRZ, 2'd0, 3, 3);   // 4-cycle memory wait
        vecs[10] = mk(0, 0, 0, 1, 0, FRZ, 2'd2, 4, 3);
        vecs[11] = mk(0, 0, 0, 1, 0, FRZ, 2'd2, 5, 3);
        vecs[12] = mk(0, 0, 0, 1, 0, FRZ, 2'd2, 6, 3);
        vecs[13] = mk(0, 0, 0, 1, 1, DEF, 2'd2, 7, 3);
        vecs[14] = mk(0, 0, 0, 0, 0, DEF, 2'd0, 7, 3);
        vecs[15] = mk(1, 1, 0, 1, 0, FRZ, 2'd0, 7, 3);   // all events at once
        vecs[16] = mk(1, 1, 0, 1, 1, BRN, 2'd2, 8, 3);
        vecs[17] = mk(0, 0, 0, 0, 0, DEF, 2'd0, 8, 4);
        vecs[18] = mk(1, 0, 0, 0, 0, STL, 2'd0, 8, 4);   // mem wait inside LOAD_STALL
        vecs[19] = mk(0, 0, 0, 1, 0, FRZ, 2'd1, 9, 4);
        vecs[20] = mk(0, 0, 0, 1, 1, STL, 2'd2, 10, 4);
        vecs[21] = mk(0, 0, 0, 0, 0, DEF, 2'd0, 11, 4);

        // reset held for 3 cycles
        chk("reset_ctl", 32'(ctl_now()), 32'(RST));
        tick(); tick(); tick();
        drive(0, 0, 0, 0, 0);
        chk("reset_ctl_held", 32'(ctl_now()), 32'(RST));
        chk("reset_state", 32'(bus.State), 32'd0);
        chk("reset_stall_cnt", bus.StallCount, 32'd0);
        chk("reset_flush_cnt", bus.FlushCount, 32'd0);
        chk("reset_mem_err", 32'(bus.MemError), 32'd0);
        rst = 1'b1;
        tick();

        for (int i = 0; i < 22; i++) begin
            drive(vecs[i].lu, vecs[i].br, vecs[i].jp, vecs[i].mreq, vecs[i].mrdy);
            chk($sformatf("vec%0d_ctl", i), 32'(ctl_now()), 32'(vecs[i].ctl));
            chk($sformatf("vec%0d_state", i), 32'(bus.State), 32'(vecs[i].st));
            chk($sformatf("vec%0d_stall_cnt", i), bus.StallCount, 32'(vecs[i].sc));
            chk($sformatf("vec%0d_flush_cnt", i), bus.FlushCount, 32'(vecs[i].fc));
            chk($sformatf("vec%0d_mem_err", i), 32'(bus.MemError), 32'd0);
            tick();
        end

        // timeout: 10 cycles of MemReady=0 with MEM_TIMEOUT=8
        for (int i = 1; i <= 10; i++) begin
            drive(0, 0, 0, 1, 0);
            chk($sformatf("to%0d_ctl", i), 32'(ctl_now()), 32'(FRZ));
            tick();
            if (i == 7) chk("timeout_not_yet", 32'(bus.MemError), 32'd0);
            if (i == 8) chk("timeout_set", 32'(bus.MemError), 32'd1);
        end
        chk("timeout_held", 32'(bus.MemError), 32'd1);
        drive(0, 0, 0, 1, 1);
        chk("timeout_release_ctl", 32'(ctl_now()), 32'(DEF));
        tick();
        drive(0, 0, 0, 0, 0);
        chk("timeout_after_ready_state", 32'(bus.State), 32'd0);
        chk("timeout_sticky", 32'(bus.MemError), 32'd1);
        tick();
        chk("timeout_sticky2", 32'(bus.MemError), 32'd1);

        // reset mid-MEM_WAIT
        drive(0, 0, 0, 1, 0);
        tick(); tick();
        chk("midwait_state", 32'(bus.State), 32'd2);
        rst = 1'b0;
        drive(0, 0, 0, 1, 0);
        chk("midwait_rst_ctl", 32'(ctl_now()), 32'(RST));
        tick();
        rst = 1'b1;
        drive(0, 0, 0, 0, 0);
        chk("midwait_rst_state", 32'(bus.State), 32'd0);
        chk("midwait_rst_err", 32'(bus.MemError), 32'd0);
        chk("midwait_rst_stall_cnt", bus.StallCount, 32'd0);
        chk("midwait_rst_flush_cnt", bus.FlushCount, 32'd0);
        chk("midwait_rst_ctl_after", 32'(ctl_now()), 32'(DEF));
        tick();

        // reset mid-LOAD_STALL
        drive(1, 0, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0);
        chk("midstall_state", 32'(bus.State), 32'd1);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        drive(0, 0, 0, 0, 0);
        chk("midstall_rst_state", 32'(bus.State), 32'd0);
        chk("midstall_rst_ctl", 32'(ctl_now()), 32'(DEF));
        tick();
        chk("midstall_next_state", 32'(bus.State), 32'd0);
        chk("midstall_stall_cnt", bus.StallCount, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
